led_output_stage: RTL
=====================

# led_output_stage

Registered output stage between `led_controller` and the board LED pins. It takes the combinational 16-bit `led_status` word and stretches short error pulses into a visible, time-limited blink on LED[0]. All other bits pass through registered, so pins are glitch-free. It sits directly downstream of `led_controller` and is the only driver of the physical LED bus.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BLINK_HZ`, 2: error LED blink rate. Full on+off period is 1/BLINK_HZ.
- `ERR_HOLD_MS`, 3000: error display duration after the error input drops. Must be ≥1.
- `DIM_DUTY`, 4: on-slots out of 16 for dimmed bits. Used only with `LED_PWM_DIM_EN`. Range 0..16.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `led_status` in 16: word from `led_controller`. Bit 0 is the error flag.
- `err_ack` in 1: single-cycle request to clear a decaying error display early.
- `led_out` out 16: registered LED pin drive.
- `err_active` out 1: high while the error display is running.

## Operation
- Input register `stat_q <= led_status` on every clock.
- Error FSM (`led_err_state_t`):
  - `ERR_IDLE`: `err_active`=0. If `stat_q[0]`=1, go to `ERR_ON`, reset the blink counter and set `blink_phase`=1.
  - `ERR_ON`: input error still asserted; hold counter is not running. When `stat_q[0]`=0, go to `ERR_DECAY`, load `hold_cnt`=ERR_HOLD_MS−1 and reset the ms prescaler to 0.
  - `ERR_DECAY`: decrement `hold_cnt` on each ms tick.
    - `stat_q[0]`=1: back to `ERR_ON`. Blink phase is not reset.
    - ms tick with `hold_cnt`=0: go to `ERR_IDLE`.
    - `err_ack`=1 with `stat_q[0]`=0: go to `ERR_IDLE` immediately.
  - `err_ack` has no effect in `ERR_IDLE` or `ERR_ON`. If `err_ack` and `stat_q[0]`=1 arrive together, the error wins.
- `err_active` = (state ≠ `ERR_IDLE`), registered.
- Blink generator:
  - Counter period is CLK_FREQ_HZ/(2·BLINK_HZ) cycles; `blink_phase` toggles on each wrap.
  - Counter runs only while `err_active`=1.
- ms prescaler period is CLK_FREQ_HZ/1000 cycles; it produces a 1-cycle `ms_tick`.
- Output register:
  - `led_out[0]` <= `err_active_next` & `blink_phase_next`.
  - `led_out[15:1]` <= `stat_q[15:1]`.
- Counter widths use `$clog2` of the period. Division is by integer truncation. A zero period is a parameter error and must trigger an elaboration-time `$error`.

## Timing
- Reset values (asynchronous): `led_out`=0, `err_active`=0, state `ERR_IDLE`, all counters 0, `blink_phase`=0.
- Latency for bits 15:1: change on `led_status` appears on `led_out` 2 clocks later.
- Error onset: `led_status[0]` rising at edge N gives `led_out[0]`=1 and `err_active`=1 at edge N+2.
- Decay length: exactly ERR_HOLD_MS·(CLK_FREQ_HZ/1000) cycles from entering `ERR_DECAY` to `ERR_IDLE`.
- Early clear: `err_ack` sampled at edge N in `ERR_DECAY` gives `err_active`=0 and `led_out[0]`=0 at edge N+1.
- Reset mid-display: all outputs return to 0 asynchronously. There is no residual blink after reset release.

## Configuration
- Macro: `LED_PWM_DIM_EN`.
- Defined:
  - A free-running 4-bit PWM slot counter gates `led_out[15:1]`: a bit is on only when slot < DIM_DUTY.
  - LED[0] is never dimmed.
  - DIM_DUTY=16 means full on; DIM_DUTY=0 means bits 15:1 are always off.
- Undefined: no PWM counter is built, `DIM_DUTY` is ignored, and bits 15:1 are a pure 2-cycle pass-through.

## Structure
- Shared package `project_pkg` holds:
  - `led_err_state_t` (`ERR_IDLE`, `ERR_ON`, `ERR_DECAY`).
  - `LED_ERR_BIT` = 0.
  - `LED_PWM_SLOTS` = 16.
- One sub-module, `led_tick_gen`:
  - Parameterised divide-by-N counter with a synchronous clear and a 1-cycle tick output.
  - Instantiated twice, once for the ms tick and once for the blink tick.

## Test plan
All scenarios use CLK_FREQ_HZ=1000 (ms tick every cycle), BLINK_HZ=100 (half period 5 cycles) and ERR_HOLD_MS=20, with the macro undefined unless stated.
- Reset, then drive `led_status`=16'h8000 → `led_out`=16'h8000 two cycles later; `err_active`=0.
- 1-cycle pulse on `led_status[0]` → `err_active` high for 21 cycles; `led_out[0]` shows the pattern 5 on / 5 off starting high; then idle.
- Hold `led_status[0]` high for 100 cycles → `err_active` stays high throughout, and decay of 20 cycles starts only after release.
- `err_ack` 5 cycles into decay → `led_out[0]`=0 and `err_active`=0 on the next edge. Repeat with `err_ack` coinciding with the error input → no clear.
- `rst_n` low mid-blink → `led_out`=0 asynchronously. After release with `led_status`=0, outputs stay 0.
- `LED_PWM_DIM_EN` defined, DIM_DUTY=4, `led_status`=16'hF800 → bits 15:11 high for 4 of every 16 cycles; DIM_DUTY=16 → always high.

Source files
------------

// File: rtl/project_pkg.sv
// project_pkg: shared LED error-display types and constants.
// Holds led_err_state_t, the error bit index and the PWM slot count.
package project_pkg;
  typedef enum logic [1:0] {
    ERR_IDLE  = 2'd0,
    ERR_ON    = 2'd1,
    ERR_DECAY = 2'd2
  } led_err_state_t;
  localparam int LED_ERR_BIT   = 0;
  localparam int LED_PWM_SLOTS = 16;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: divide-by-N counter producing a 1-cycle tick every N enabled cycles.
// Ports: clk, rst_n (async active-low), clr (sync clear to 0), en (count enable), tick (1-cycle pulse).
module led_tick_gen #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  if (N < 1) begin : g_bad_period
    $error("led_tick_gen: period must be at least 1 cycle");
  end
  assign tick = en && (cnt == W'(N - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_output_stage.sv
// led_output_stage: registered LED pin driver that stretches error pulses into a timed blink on LED[0].
// Ports: clk, rst_n (async active-low), led_status[15:0] (bit 0 = error flag),
//        err_ack (early clear of a decaying error), led_out[15:0] (registered pins),
//        err_active (error display running).
// Optional: define LED_PWM_DIM_EN to dim bits 15:1 to DIM_DUTY of 16 PWM slots.
module led_output_stage
  import project_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BLINK_HZ    = 2,
  parameter int ERR_HOLD_MS = 3000,
  parameter int DIM_DUTY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] led_status,
  input  logic        err_ack,
  output logic [15:0] led_out,
  output logic        err_active
);
  localparam int MS_DIV    = CLK_FREQ_HZ / 1000;
  localparam int BLINK_DIV = (BLINK_HZ > 0) ? CLK_FREQ_HZ / (2 * BLINK_HZ) : 0;
  localparam int HW        = (ERR_HOLD_MS > 1) ? $clog2(ERR_HOLD_MS) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(ERR_HOLD_MS - 1);
  if (ERR_HOLD_MS < 1) begin : g_bad_hold
    $error("led_output_stage: ERR_HOLD_MS must be at least 1");
  end
  if (DIM_DUTY < 0 || DIM_DUTY > LED_PWM_SLOTS) begin : g_bad_duty
    $error("led_output_stage: DIM_DUTY out of range");
  end
  logic [15:0]    stat_q;
  logic           ack_q;
  logic           err_bit;
  led_err_state_t state, state_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic           blink_phase, phase_nx;
  logic           err_nx;
  logic           ms_tick, ms_clr;
  logic           blink_tick, blink_clr;
  logic           dim_on;
  assign err_bit = stat_q[LED_ERR_BIT];
  // The ms prescaler restarts on entry to decay so the hold time is exact.
  led_tick_gen #(.N(MS_DIV)) u_ms_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ms_clr),
    .en   (1'b1),
    .tick (ms_tick)
  );
  // The blink counter only advances while the display is active and restarts on a fresh error.
  led_tick_gen #(.N(BLINK_DIV)) u_blink_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (blink_clr),
    .en   (err_active),
    .tick (blink_tick)
  );
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    ms_clr   = 1'b0;
    case (state)
      ERR_IDLE:  if (err_bit) state_nx = ERR_ON;
      ERR_ON:    if (!err_bit) begin
                   state_nx = ERR_DECAY;
                   hold_nx  = HOLD_INIT;
                   ms_clr   = 1'b1;
                 end
      ERR_DECAY: if (err_bit) state_nx = ERR_ON;
                 else if (ack_q) state_nx = ERR_IDLE;
                 else if (ms_tick) begin
                   if (hold_cnt == '0) state_nx = ERR_IDLE;
                   else hold_nx = hold_cnt - 1'b1;
                 end
      default:   state_nx = ERR_IDLE;
    endcase
  end
  assign blink_clr = (state == ERR_IDLE) && err_bit;
  assign phase_nx  = blink_clr ? 1'b1 : blink_tick ? ~blink_phase : blink_phase;
  assign err_nx    = (state_nx != ERR_IDLE);
`ifdef LED_PWM_DIM_EN
  localparam int SW = $clog2(LED_PWM_SLOTS);
  logic [SW-1:0] slot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else slot <= slot + 1'b1;
  assign dim_on = {1'b0, slot} < (SW + 1)'(DIM_DUTY);
`else
  assign dim_on = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_q      <= '0;
      ack_q       <= 1'b0;
      state       <= ERR_IDLE;
      hold_cnt    <= '0;
      blink_phase <= 1'b0;
      err_active  <= 1'b0;
      led_out     <= '0;
    end else begin
      stat_q      <= led_status;
      ack_q       <= err_ack;
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      blink_phase <= phase_nx;
      err_active  <= err_nx;
      led_out     <= {stat_q[15:1] & {15{dim_on}}, err_nx & phase_nx};
    end
endmodule
